tpuv1_host_seq: RTL

Bus-initiator sequencer that drives the TPU's memory-mapped slave port (r_w/addr/dataIn/dataOut) from a valid/ready word stream. It loads A rows, B rows and the C accumulator image, writes the start register, idles for the multiply latency, then reads C back and emits it on an output stream. It sits between the host-side DMA/FIFO and the `tpuv1` instance and owns that bus exclusively.

---
 rtl/tpuv1_host_seq_if.sv | 45 ++++
 rtl/tpuv1_host_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tpuv1_host_seq_if.sv
// Bundle of the host word streams and the TPU slave-port bus driven by
// tpuv1_host_seq.
//   master : the sequencer (drives the TPU bus, in_ready, out_*, busy, done)
//   slave  : its surroundings (host DMA/FIFO on the streams, TPU on the bus)
//
// Handshake: a stream word transfers on a rising clk edge where valid and
// ready are both high. The producer holds valid and data stable until that
// edge, and valid never waits on ready. Here ready (in_ready) is a register
// and never depends combinationally on valid.
interface tpuv1_host_seq_if #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
);
    // Host -> sequencer word stream (A rows, B rows, C half-rows)
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] in_data;

    // Sequencer -> host result stream (C half-rows)
    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] out_data;

    // Job status
    logic             busy;
    logic             done;

    // TPU memory-mapped slave port
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_wdata;
    logic [DATAW-1:0] tpu_rdata;

    modport master (
        input  in_valid, in_data, out_ready, tpu_rdata,
        output in_ready, out_valid, out_data, busy, done,
               tpu_r_w, tpu_addr, tpu_wdata
    );

    modport slave (
        output in_valid, in_data, out_ready, tpu_rdata,
        input  in_ready, out_valid, out_data, busy, done,
               tpu_r_w, tpu_addr, tpu_wdata
    );
endinterface

// File: rtl/tpuv1_host_seq.sv
// tpuv1_host_seq: bus initiator that feeds a tpuv1 instance from a word
// stream. One job = load A rows, load B rows, load the C accumulator image,
// write the start register, idle for the multiply latency, then read C back
// half-row by half-row onto the output stream.
//
// Optional feature macro: TPU_HOST_CZERO_EN
//   defined   : the C image is not taken from the stream; the block writes
//               2*DIM zero words itself (2*DIM input words per job).
//   undefined : the C image comes from the stream (4*DIM input words per job).
//
// Every bus and stream output is a register: a word accepted at edge N is on
// the bus during the following cycle and the TPU samples it at edge N+1.
// dbg_state exposes the FSM state encoding for checkers.
module tpuv1_host_seq #(
    parameter int BITS_AB  = 8,
    parameter int BITS_C   = 16,
    parameter int DIM      = 8,
    parameter int ADDRW    = 16,
    parameter int DATAW    = 64,
    parameter int WAIT_CYC = 3*DIM
) (
    input  logic             clk,
    input  logic             rst_n,
    tpuv1_host_seq_if.master bus,
    output logic [2:0]       dbg_state
);

    // Row / half-row index covers 0..2*DIM-1 (A and B only use 0..DIM-1).
    localparam int IDXW = $clog2(2*DIM);
    localparam int WCW  = $clog2(WAIT_CYC + 1);

    localparam logic [IDXW-1:0] LAST_AB = IDXW'(DIM - 1);
    localparam logic [IDXW-1:0] LAST_C  = IDXW'(2*DIM - 1);
    localparam logic [WCW-1:0]  WAIT_LD = WCW'(WAIT_CYC);

    // TPU address map. A/B rows and C half-rows sit on 8-byte strides, so
    // C row r low half is slot 2r and its high half is slot 2r+1.
    localparam logic [ADDRW-1:0] BASE_A     = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] BASE_B     = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] BASE_C     = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] START_ADDR = ADDRW'(16'h0400);

    // A row must fill one bus word, a C row exactly two, and the idle time
    // must cover the array latency. A mis-parameterised instance never
    // raises in_ready, so it can never push garbage into the TPU.
    localparam logic CFG_OK = (DIM*BITS_AB == DATAW) &&
                              (DIM*BITS_C == 2*DATAW) &&
                              (WAIT_CYC >= 3*DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_LOAD_C = 3'd3,
        S_START  = 3'd4,
        S_WAIT   = 3'd5,
        S_READ   = 3'd6,
        S_DRAIN  = 3'd7
    } state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    logic [WCW-1:0]  wait_cnt;
    logic            accept;

    // Bus address of slot i above a region base (8-byte stride).
    function automatic logic [ADDRW-1:0] slot_addr(input logic [ADDRW-1:0] base,
                                                   input logic [IDXW-1:0]  i);
        return base + (ADDRW'(i) << 3);
    endfunction

    // A word is taken only when the registered in_ready was already high.
    assign accept    = bus.in_valid && bus.in_ready;
    assign dbg_state = state;

    // Sequencer FSM: state, counters and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            wait_cnt      <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.tpu_r_w   <= 1'b0;
            bus.tpu_addr  <= '0;
            bus.tpu_wdata <= '0;
        end else begin
            // Bus returns to idle and done drops unless a branch below
            // issues a cycle / pulse for the coming clock.
            bus.tpu_r_w   <= 1'b0;
            bus.tpu_addr  <= '0;
            bus.tpu_wdata <= '0;
            bus.done      <= 1'b0;

            case (state)
                S_IDLE: begin
                    bus.in_ready <= CFG_OK;
                    if (accept) begin
                        // First word of a job is always A row 0.
                        bus.tpu_r_w   <= 1'b1;
                        bus.tpu_addr  <= BASE_A;
                        bus.tpu_wdata <= bus.in_data;
                        idx           <= IDXW'(1);
                        bus.busy      <= 1'b1;
                        state         <= S_LOAD_A;
                    end
                end

                S_LOAD_A: begin
                    if (accept) begin
                        bus.tpu_r_w   <= 1'b1;
                        bus.tpu_addr  <= slot_addr(BASE_A, idx);
                        bus.tpu_wdata <= bus.in_data;
                        if (idx == LAST_AB) begin
                            idx   <= '0;
                            state <= S_LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                S_LOAD_B: begin
                    if (accept) begin
                        bus.tpu_r_w   <= 1'b1;
                        bus.tpu_addr  <= slot_addr(BASE_B, idx);
                        bus.tpu_wdata <= bus.in_data;
                        if (idx == LAST_AB) begin
                            idx   <= '0;
                            state <= S_LOAD_C;
`ifdef TPU_HOST_CZERO_EN
                            // C image is self-generated: stop taking input now.
                            bus.in_ready <= 1'b0;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                S_LOAD_C: begin
`ifdef TPU_HOST_CZERO_EN
                    // One zero write per cycle, no input consumed.
                    bus.tpu_r_w   <= 1'b1;
                    bus.tpu_addr  <= slot_addr(BASE_C, idx);
                    bus.tpu_wdata <= '0;
                    if (idx == LAST_C) begin
                        idx   <= '0;
                        state <= S_START;
                    end else begin
                        idx <= idx + 1'b1;
                    end
`else
                    // Half-rows arrive row0-low, row0-high, row1-low, ...
                    if (accept) begin
                        bus.tpu_r_w   <= 1'b1;
                        bus.tpu_addr  <= slot_addr(BASE_C, idx);
                        bus.tpu_wdata <= bus.in_data;
                        if (idx == LAST_C) begin
                            idx          <= '0;
                            bus.in_ready <= 1'b0;
                            state        <= S_START;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
`endif
                end

                S_START: begin
                    // Start register write directly follows the last C write;
                    // its data is ignored by the TPU and sent as zero.
                    bus.tpu_r_w  <= 1'b1;
                    bus.tpu_addr <= START_ADDR;
                    wait_cnt     <= WAIT_LD;
                    state        <= S_WAIT;
                end

                S_WAIT: begin
                    // Loaded with WAIT_CYC, so the bus shows exactly WAIT_CYC
                    // idle cycles between the start write and the first read.
                    if (wait_cnt == '0) begin
                        bus.tpu_addr <= slot_addr(BASE_C, idx);
                        state        <= S_READ;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                S_READ: begin
                    // The read address is on the bus this cycle; the TPU
                    // answers within the cycle, so capture at its end.
                    bus.out_data  <= bus.tpu_rdata;
                    bus.out_valid <= 1'b1;
                    state         <= S_DRAIN;
                end

                S_DRAIN: begin
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (idx == LAST_C) begin
                            // Back to IDLE with in_ready already high so the
                            // next job's first word can go in the done cycle.
                            idx          <= '0;
                            bus.done     <= 1'b1;
                            bus.busy     <= 1'b0;
                            bus.in_ready <= CFG_OK;
                            state        <= S_IDLE;
                        end else begin
                            idx          <= idx + 1'b1;
                            bus.tpu_addr <= slot_addr(BASE_C, idx + 1'b1);
                            state        <= S_READ;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
